// File: rtl/alu_muldiv_seq.sv
// Multicycle sequencer in front of the execute-stage ALU: single-cycle ops pass through,
// MULT/MULTU/DIV/DIVU iterate 32 steps on the ALU adder/subtractor and return HI/LO.
module alu_muldiv_seq #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned ITER  = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clk_en,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [5:0]       req_func,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [5:0]       alu_func,
   input  logic [WIDTH-1:0] alu_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_hi,
   output logic [WIDTH-1:0] rsp_lo,
   output logic             rsp_divz,
   output logic             busy
);

   localparam logic [5:0] FN_MULT  = 6'd24;
   localparam logic [5:0] FN_MULTU = 6'd25;
   localparam logic [5:0] FN_DIV   = 6'd26;
   localparam logic [5:0] FN_DIVU  = 6'd27;
   localparam logic [5:0] FN_ADD   = 6'd32;
   localparam logic [5:0] FN_SUB   = 6'd34;
   localparam int unsigned CW = $clog2(ITER);
   localparam logic [CW-1:0] LAST = CW'(ITER - 1);

   typedef enum logic [2:0] {IDLE, SINGLE, MUL, DIV, FIX, DONE} state_t;

   state_t           state;
   logic [5:0]       func_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic [CW-1:0]    cnt;
   logic             op_mul;
   logic             neg_p;
   logic             neg_r;

   logic             req_mul;
   logic             req_div;
   logic             req_sgn;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic [WIDTH-1:0] shl_rem;
   logic             mul_carry;
   logic             div_ge;
   logic [2*WIDTH-1:0] fix_prod;
   logic [WIDTH-1:0] fix_quo;
   logic [WIDTH-1:0] fix_rem;

   assign req_ready = (state == IDLE) && clk_en;
   assign busy      = (state != IDLE);
   assign rsp_valid = (state == DONE);

   assign req_mul = (req_func == FN_MULT) || (req_func == FN_MULTU);
   assign req_div = (req_func == FN_DIV)  || (req_func == FN_DIVU);
   assign req_sgn = (req_func == FN_MULT) || (req_func == FN_DIV);
   assign abs_a   = (req_sgn && req_a[WIDTH-1]) ? ('0 - req_a) : req_a;
   assign abs_b   = (req_sgn && req_b[WIDTH-1]) ? ('0 - req_b) : req_b;

   // Partial remainder is shifted left pulling in the dividend MSB; the bit shifted out
   // of the top means the 33-bit value already exceeds the divisor.
   assign shl_rem   = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
   assign div_ge    = acc_hi[WIDTH-1] || (shl_rem >= b_q);
   assign mul_carry = (alu_result < alu_a);

   always_comb begin
      alu_a    = '0;
      alu_b    = '0;
      alu_func = FN_ADD;
      case (state)
         SINGLE: begin
            alu_a    = a_q;
            alu_b    = b_q;
            alu_func = func_q;
         end
         MUL: begin
            alu_a    = acc_hi;
            alu_b    = acc_lo[0] ? a_q : '0;
            alu_func = FN_ADD;
         end
         DIV: begin
            alu_a    = shl_rem;
            alu_b    = b_q;
            alu_func = FN_SUB;
         end
         default: ;
      endcase
   end

   always_comb begin
      fix_prod = neg_p ? ('0 - {acc_hi, acc_lo}) : {acc_hi, acc_lo};
      fix_quo  = neg_p ? ('0 - acc_lo) : acc_lo;
      fix_rem  = neg_r ? ('0 - acc_hi) : acc_hi;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         func_q   <= FN_ADD;
         a_q      <= '0;
         b_q      <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         cnt      <= '0;
         op_mul   <= 1'b0;
         neg_p    <= 1'b0;
         neg_r    <= 1'b0;
         rsp_hi   <= '0;
         rsp_lo   <= '0;
         rsp_divz <= 1'b0;
      end else if (clk_en) begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  func_q   <= req_func;
                  cnt      <= '0;
                  op_mul   <= req_mul;
                  rsp_divz <= 1'b0;
                  neg_p    <= req_sgn && (req_a[WIDTH-1] ^ req_b[WIDTH-1]);
                  neg_r    <= req_sgn && req_a[WIDTH-1];
                  acc_hi   <= '0;
                  if (req_mul) begin
                     a_q    <= abs_a;
                     b_q    <= '0;
                     acc_lo <= abs_b;
                     state  <= MUL;
                  end else if (req_div) begin
                     a_q    <= '0;
                     b_q    <= abs_b;
                     acc_lo <= abs_a;
                     if (req_b == '0) begin
                        rsp_divz <= 1'b1;
                        rsp_hi   <= req_a;
                        rsp_lo   <= '1;
                        state    <= DONE;
                     end else begin
                        state <= DIV;
                     end
                  end else begin
                     a_q    <= req_a;
                     b_q    <= req_b;
                     acc_lo <= '0;
                     state  <= SINGLE;
                  end
               end
            end
            SINGLE: begin
               rsp_lo <= alu_result;
               rsp_hi <= '0;
               state  <= DONE;
            end
            MUL: begin
               {acc_hi, acc_lo} <= {mul_carry, alu_result, acc_lo[WIDTH-1:1]};
               cnt <= cnt + 1'b1;
               if (cnt == LAST) state <= FIX;
            end
            DIV: begin
               acc_hi <= div_ge ? alu_result : shl_rem;
               acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) state <= FIX;
            end
            FIX: begin
               if (op_mul) begin
                  {rsp_hi, rsp_lo} <= fix_prod;
               end else begin
                  rsp_hi <= fix_rem;
                  rsp_lo <= fix_quo;
               end
               state <= DONE;
            end
            DONE: begin
               if (rsp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomized bench for alu_muldiv_seq: a behavioural ALU drives alu_result and a
// plain-arithmetic model predicts every response, latency and handshake level.
module tb_alu_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clk_en = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [5:0]  req_func = 6'd32;
   logic [31:0] req_a = '0;
   logic [31:0] req_b = '0;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [5:0]  alu_func;
   logic [31:0] alu_result;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_hi;
   logic [31:0] rsp_lo;
   logic        rsp_divz;
   logic        busy;

   int checks = 0;
   int errors = 0;

   bit          pending = 1'b0;
   logic [31:0] exp_hi = '0;
   logic [31:0] exp_lo = '0;
   logic        exp_divz = 1'b0;
   logic [31:0] last_hi, last_lo;
   logic        last_divz;

   alu_muldiv_seq #(.WIDTH(32), .ITER(32)) dut (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
      .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
      .req_a(req_a), .req_b(req_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_divz(rsp_divz), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [5:0] f);
      case (f)
         6'd32, 6'd33: return a + b;
         6'd34, 6'd35: return a - b;
         6'd36: return a & b;
         6'd37: return a | b;
         6'd38: return a ^ b;
         6'd39: return ~(a | b);
         6'd42: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         6'd43: return (a < b) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   always_comb alu_result = alu_fn(alu_a, alu_b, alu_func);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output logic dz, output int lat);
      logic signed [63:0] sp;
      logic [63:0] up;
      dz = 1'b0;
      lat = 34;
      hi = '0;
      lo = '0;
      case (f)
         6'd24: begin
            sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            {hi, lo} = sp;
         end
         6'd25: begin
            up = {32'd0, a} * {32'd0, b};
            {hi, lo} = up;
         end
         6'd26, 6'd27: begin
            if (b == 32'd0) begin
               dz = 1'b1; hi = a; lo = 32'hFFFF_FFFF; lat = 1;
            end else if (f == 6'd26 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               lo = 32'h8000_0000; hi = 32'd0;
            end else if (f == 6'd26) begin
               lo = $signed(a) / $signed(b);
               hi = $signed(a) % $signed(b);
            end else begin
               lo = a / b;
               hi = a % b;
            end
         end
         default: begin
            lo = alu_fn(a, b, f); hi = '0; lat = 2;
         end
      endcase
   endtask

   // Cycle-by-cycle compare against the handshake/response model.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("busy", busy, pending);
         chk("req_ready", req_ready, !pending && clk_en);
         chk("rsp_valid_only_when_pending", rsp_valid && !pending, 0);
         if (rsp_valid) begin
            chk("rsp_hi", rsp_hi, exp_hi);
            chk("rsp_lo", rsp_lo, exp_lo);
            chk("rsp_divz", rsp_divz, exp_divz);
         end
         if (!busy) chk("alu_idle", {alu_a, alu_b}, 64'd0);
         if (!busy) chk("alu_idle_func", alu_func, 6'd32);
      end
   end

   task automatic start_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                           output int exp_lat);
      logic [31:0] eh, el;
      logic ed;
      model(f, a, b, eh, el, ed, exp_lat);
      @(negedge clk);
      req_valid = 1'b1; req_func = f; req_a = a; req_b = b;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      exp_hi = eh; exp_lo = el; exp_divz = ed;
      pending = 1'b1;
      chk("accepted", busy, 1);
   endtask

   task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit stall);
      int exp_lat;
      int lat;
      start_op(f, a, b, exp_lat);
      lat = 1;
      while (!rsp_valid && lat < 300) begin
         clk_en = !(stall && lat >= 10 && lat < 15);
         @(posedge clk);
         #1;
         lat++;
      end
      clk_en = 1'b1;
      chk("latency", lat, exp_lat + (stall ? 5 : 0));
      last_hi = rsp_hi; last_lo = rsp_lo; last_divz = rsp_divz;
      repeat (hold) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      pending = 1'b0;
      chk("rsp_drop", rsp_valid, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, req_ready, 1);
      chk({tag, "_busy_valid"}, {busy, rsp_valid, rsp_divz}, 3'b000);
      chk({tag, "_rsp"}, {rsp_hi, rsp_lo}, 64'd0);
      chk({tag, "_alu"}, {alu_a, alu_b}, 64'd0);
      chk({tag, "_alu_func"}, alu_func, 6'd32);
   endtask

   initial begin
      int dummy;
      logic [5:0] f;
      logic [31:0] a, b;
      logic [31:0] mh, ml;
      logic md;

      // Pin the model to hand-computed values.
      model(6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mh, ml, md, dummy);
      chk("model_multu", {mh, ml}, 64'hFFFF_FFFE_0000_0001);
      model(6'd26, 32'h8000_0000, 32'hFFFF_FFFF, mh, ml, md, dummy);
      chk("model_div_ovf", {mh, ml}, 64'h0000_0000_8000_0000);

      #12;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      run_op(6'd32, 32'd5, 32'd7, 0, 1'b0);
      chk("single_add_lit", {last_hi, last_lo}, 64'd12);
      run_op(6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
      chk("multu_lit", {last_hi, last_lo}, 64'hFFFF_FFFE_0000_0001);
      run_op(6'd24, 32'hFFFF_FFFD, 32'd7, 0, 1'b0);
      chk("mult_lit", {last_hi, last_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      run_op(6'd26, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
      chk("div_lit", {last_hi, last_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(6'd27, 32'd100, 32'd0, 0, 1'b0);
      chk("divz_lit", {last_divz, last_hi, last_lo}, {1'b1, 64'h0000_0064_FFFF_FFFF});
      run_op(6'd26, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
      chk("div_ovf_lit", {last_divz, last_hi, last_lo}, {1'b0, 64'h0000_0000_8000_0000});
      run_op(6'd24, 32'h1234_5678, 32'h8765_4321, 10, 1'b0);
      run_op(6'd25, 32'hDEAD_BEEF, 32'h0000_1001, 0, 1'b1);

      // Reset during iteration 10 of a multiply aborts it immediately.
      start_op(6'd25, 32'hCAFE_F00D, 32'h1357_9BDF, dummy);
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      pending = 1'b0;
      #1;
      check_reset_outputs("midop_reset");
      @(negedge clk);
      rst_n = 1'b1;
      run_op(6'd27, 32'd1000, 32'd7, 0, 1'b0);
      chk("post_reset_lit", {last_hi, last_lo}, {32'd6, 32'd142});

      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 5))
            0: f = 6'd24;
            1: f = 6'd25;
            2: f = 6'd26;
            3: f = 6'd27;
            default: f = 6'($urandom_range(32, 43));
         endcase
         a = $urandom();
         b = $urandom();
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 15));
            2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            3: a = 32'($urandom_range(0, 255));
            default: ;
         endcase
         run_op(f, a, b, $urandom_range(0, 3), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
